hs_npu_axib_mem_responder: RTL



---
 rtl/hs_npu_pkg.sv | 20 ++
 rtl/axib_if.sv | 59 +++++
 rtl/hs_npu_sram_1rw.sv | 41 ++++
 rtl/hs_npu_axib_mem_responder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/hs_npu_pkg.sv
// hs_npu_pkg: shared NPU types and constants.
// AXI response codes, burst/size constants, responder FSM states.
package hs_npu_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } axi_resp_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_WR_RESP
  } state_t;

endpackage

// File: rtl/axib_if.sv
// axib_if: AXI4 burst bundle (AR/AW/W/R/B), 32-bit data.
// Modports: s = responder side, m = master side.
interface axib_if;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;

  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport s (
    input  araddr, arlen, arsize, arburst, arvalid,
    output arready,
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output rdata, rresp, rlast, rvalid,
    input  rready,
    output bresp, bvalid,
    input  bready
  );

  modport m (
    output araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  rdata, rresp, rlast, rvalid,
    output rready,
    input  bresp, bvalid,
    output bready
  );
endinterface

// File: rtl/hs_npu_sram_1rw.sv
// hs_npu_sram_1rw: single-port DEPTH x 32 array, byte writes, registered read.
// Ports: clk, rst_n, en_i, we_i[3:0], addr_i, wdata_i, rdata_o.
module hs_npu_sram_1rw #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Contents survive reset.
  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (we_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Read register only moves on a pure read, so it holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (en_i && (we_i == 4'b0000)) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/hs_npu_axib_mem_responder.sv
// hs_npu_axib_mem_responder: AXI4 INCR burst responder over a word array.
// Ports: clk, rst_n, axi (axib_if.s).
module hs_npu_axib_mem_responder
  import hs_npu_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [7:0]  MAX_LEN     = 8'd15
) (
  input  logic clk,
  input  logic rst_n,
  axib_if.s    axi
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  state_t      state_q, state_d;
  logic        pref_rd_q, pref_rd_d;
  logic        live_q;
  logic [31:0] idx_q, idx_d;
  logic [7:0]  len_q, len_d;
  logic [8:0]  beat_q, beat_d;
  logic        err_q, err_d;
  logic        berr_q, berr_d;

  logic          ar_rdy, aw_rdy;
  logic          ar_hs, aw_hs, addr_hs;
  logic [31:0]   a_addr;
  logic [7:0]    a_len;
  logic [2:0]    a_size;
  logic [1:0]    a_burst;
  logic [33:0]   a_ofs;
  logic [31:0]   a_idx;
  logic [31:0]   idx_nx;
  logic          in_rng;
  logic          last_beat;
  logic          bad_rd;
  logic          rd_hs;
  logic          wr_beat;
  logic          wr_ok;
  logic          unused_lo;

  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;

  // Ready stays up regardless of its own valid; only the
  // competing channel on the preferred side pulls it down.
  assign ar_rdy = live_q && (state_q == ST_IDLE)
                  && !(axi.awvalid && !pref_rd_q);
  assign aw_rdy = live_q && (state_q == ST_IDLE)
                  && !(axi.arvalid && pref_rd_q);

  assign ar_hs   = axi.arvalid && ar_rdy;
  assign aw_hs   = axi.awvalid && aw_rdy;
  assign addr_hs = ar_hs || aw_hs;

  assign a_addr  = ar_hs ? axi.araddr  : axi.awaddr;
  assign a_len   = ar_hs ? axi.arlen   : axi.awlen;
  assign a_size  = ar_hs ? axi.arsize  : axi.awsize;
  assign a_burst = ar_hs ? axi.arburst : axi.awburst;

  // Signed word index: an address below BASE_ADDR becomes a
  // huge unsigned index and so fails the range check.
  assign a_ofs     = {2'b00, a_addr} - {2'b00, BASE_ADDR};
  assign a_idx     = a_ofs[33:2];
  assign unused_lo = ^a_ofs[1:0];

  assign idx_nx    = idx_q + 32'd1;
  assign in_rng    = idx_q < DEPTH_WORDS;
  assign last_beat = beat_q == {1'b0, len_q};
  assign bad_rd    = err_q || !in_rng;
  assign rd_hs     = (state_q == ST_RD) && axi.rready;
  assign wr_beat   = (state_q == ST_WR) && axi.wvalid;
  assign wr_ok     = !err_q && in_rng;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ar_hs) begin
          state_d = ST_RD;
        end else if (aw_hs) begin
          state_d = ST_WR;
        end
      end
      ST_RD: begin
        if (axi.rready && last_beat) begin
          state_d = ST_IDLE;
        end
      end
      ST_WR: begin
        // Early or missing wlast also ends the burst.
        if (axi.wvalid && (last_beat || axi.wlast)) begin
          state_d = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (axi.bready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    axi.arready = ar_rdy;
    axi.awready = aw_rdy;
    axi.wready  = state_q == ST_WR;
    axi.rvalid  = state_q == ST_RD;
    axi.rlast   = (state_q == ST_RD) && last_beat;
    axi.rdata   = '0;
    axi.rresp   = OKAY;
    axi.bvalid  = state_q == ST_WR_RESP;
    axi.bresp   = OKAY;
    if (state_q == ST_RD) begin
      if (bad_rd) begin
        axi.rresp = SLVERR;
      end else begin
        axi.rdata = mem_rdata;
      end
    end
    if ((state_q == ST_WR_RESP) && berr_q) begin
      axi.bresp = SLVERR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q    <= 1'b0;
      pref_rd_q <= 1'b1;
      idx_q     <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      err_q     <= 1'b0;
      berr_q    <= 1'b0;
    end else begin
      live_q    <= 1'b1;
      pref_rd_q <= pref_rd_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      err_q     <= err_d;
      berr_q    <= berr_d;
    end
  end

  always_comb begin
    pref_rd_d = pref_rd_q;
    idx_d     = idx_q;
    len_d     = len_q;
    beat_d    = beat_q;
    err_d     = err_q;
    berr_d    = berr_q;
    if (addr_hs) begin
      idx_d  = a_idx;
      len_d  = a_len;
      beat_d = '0;
      berr_d = 1'b0;
      err_d  = (a_size != AXI_SIZE_WORD)
               || (a_burst != AXI_BURST_INCR)
               || (a_len > MAX_LEN);
      if (axi.arvalid && axi.awvalid) begin
        pref_rd_d = !pref_rd_q;
      end
    end
    if (rd_hs || wr_beat) begin
      idx_d  = idx_nx;
      beat_d = beat_q + 9'd1;
    end
    // wlast must coincide exactly with the final beat.
    if (wr_beat && (!wr_ok || (axi.wlast != last_beat))) begin
      berr_d = 1'b1;
    end
  end

  // Single port: first read on AR, prefetch next on each R
  // handshake, byte writes on accepted W beats.
  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 4'b0000;
    mem_addr = idx_q[AW-1:0];
    unique case (1'b1)
      ar_hs: begin
        mem_en   = 1'b1;
        mem_addr = a_idx[AW-1:0];
      end
      rd_hs: begin
        mem_en   = 1'b1;
        mem_addr = idx_nx[AW-1:0];
      end
      (wr_beat && wr_ok): begin
        mem_en = 1'b1;
        mem_we = axi.wstrb;
      end
      default: ;
    endcase
  end

  hs_npu_sram_1rw #(
    .DEPTH (DEPTH_WORDS)
  ) u_sram (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (mem_en),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (axi.wdata),
    .rdata_o (mem_rdata)
  );

endmodule
